// File: rtl/eth_frame_tx_gen.sv
// eth_frame_tx_gen: GMII-rate Ethernet test-frame generator.
// Sends preamble, SFD, broadcast DA, SRC_MAC, ETHERTYPE, a counting payload
// and the CRC-32 FCS, one byte per clock, followed by IPG_BYTES idle cycles.
// Ports:
//   clk        - byte clock
//   rst        - asynchronous active-high reset
//   start      - single-cycle frame request (one request is queued while busy)
//   gmii_txd   - transmit byte
//   gmii_tx_en - high for preamble, SFD, header, payload and FCS bytes
//   sfd_tx     - high in the cycle the SFD (0xD5) is driven
//   busy       - high from the first preamble byte through the last IPG cycle
//   frame_cnt  - completed-frame count, wraps at 16 bits
module eth_frame_tx_gen #(
    parameter int unsigned PAYLOAD_LEN = 46,
    parameter int unsigned IPG_BYTES   = 12,
    parameter logic [47:0] SRC_MAC     = 48'h020000000001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        sfd_tx,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned AUTO_W  = 32;
    localparam int unsigned PRE_LEN = 7;
    localparam int unsigned HDR_LEN = 14;
    localparam int unsigned FCS_LEN = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_IPG
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
    logic [7:0]          txd_q, txd_d;
    logic                tx_en_q, tx_en_d;
    logic                sfd_q, sfd_d;
    logic                busy_q, busy_d;
    logic                auto_pulse;
    logic                req;
    logic [31:0]         fcs_word;

    // One byte of reflected CRC-32 (poly 0xEDB88320).
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Header byte idx: broadcast DA, then SRC_MAC and ETHERTYPE, MSB byte first.
    function automatic logic [7:0] hdr_byte(input logic [CNT_W-1:0] idx);
        logic [47:0] sa;
        sa = SRC_MAC << (8 * (32'(idx) - 32'd6));
        if (idx < CNT_W'(6))        return 8'hFF;
        else if (idx < CNT_W'(12))  return sa[47:40];
        else if (idx == CNT_W'(12)) return ETHERTYPE[15:8];
        else                        return ETHERTYPE[7:0];
    endfunction

    // Next state, then the registered byte for whatever state comes next.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        crc_d       = crc_q;
        auto_cnt_d  = auto_cnt_q;
        auto_pulse  = 1'b0;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        sfd_d       = 1'b0;
        fcs_word    = ~crc_q;

        if (AUTO_PERIOD != 0) begin
            if (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1)) begin
                auto_cnt_d = '0;
                auto_pulse = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end
        end
        req = start | auto_pulse;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req || pending_q) begin
                    state_d   = S_PRE;
                    pending_d = 1'b0;
                end
            end
            S_PRE: begin
                pending_d = pending_q | req;
                if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end
            end
            S_SFD: begin
                pending_d = pending_q | req;
                state_d   = S_HDR;
                cnt_d     = '0;
            end
            S_HDR: begin
                pending_d = pending_q | req;
                if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                    state_d = S_PAY;
                    cnt_d   = '0;
                end
            end
            S_PAY: begin
                pending_d = pending_q | req;
                if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                pending_d = pending_q | req;
                if (cnt_q == CNT_W'(FCS_LEN - 2)) begin
                    // The next byte is the last FCS byte: count the frame with it.
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                if (cnt_q == CNT_W'(FCS_LEN - 1)) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end
            end
            S_IPG: begin
                if (cnt_q == CNT_W'(IPG_BYTES - 1)) begin
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = (req || pending_q) ? S_PRE : S_IDLE;
                end else begin
                    pending_d = pending_q | req;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            S_PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                crc_d   = 32'hFFFFFFFF;
            end
            S_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                sfd_d   = 1'b1;
            end
            S_HDR: begin
                txd_d   = hdr_byte(cnt_d);
                tx_en_d = 1'b1;
                crc_d   = crc_next(crc_q, txd_d);
            end
            S_PAY: begin
                // frame_cnt is stable for the whole frame, so byte 0 tags the frame.
                txd_d   = (cnt_d == '0) ? frame_cnt_q[7:0] : 8'(cnt_d - CNT_W'(1));
                tx_en_d = 1'b1;
                crc_d   = crc_next(crc_q, txd_d);
            end
            S_FCS: begin
                txd_d   = fcs_word[{cnt_d[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
            end
            default: begin
                txd_d   = 8'h00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            crc_q       <= 32'hFFFFFFFF;
            auto_cnt_q  <= '0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            sfd_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            crc_q       <= crc_d;
            auto_cnt_q  <= auto_cnt_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            sfd_q       <= sfd_d;
            busy_q      <= busy_d;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign sfd_tx     = sfd_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_eth_frame_tx_gen.sv
// Bench for eth_frame_tx_gen: default instance checked cycle by cycle against a
// frame-position model, plus an auto-start instance and a 1500-byte-payload instance.
module tb_eth_frame_tx_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, start0, start2, zero_start;
    logic [7:0]  g0_txd, g1_txd, g2_txd;
    logic        g0_en, g1_en, g2_en;
    logic        g0_sfd, g1_sfd, g2_sfd;
    logic        g0_busy, g1_busy, g2_busy;
    logic [15:0] g0_fcnt, g1_fcnt, g2_fcnt;

    eth_frame_tx_gen u0 (
        .clk(clk), .rst(rst0), .start(start0),
        .gmii_txd(g0_txd), .gmii_tx_en(g0_en), .sfd_tx(g0_sfd),
        .busy(g0_busy), .frame_cnt(g0_fcnt)
    );

    eth_frame_tx_gen #(.AUTO_PERIOD(200)) u1 (
        .clk(clk), .rst(rst1), .start(zero_start),
        .gmii_txd(g1_txd), .gmii_tx_en(g1_en), .sfd_tx(g1_sfd),
        .busy(g1_busy), .frame_cnt(g1_fcnt)
    );

    eth_frame_tx_gen #(.PAYLOAD_LEN(1500)) u2 (
        .clk(clk), .rst(rst1), .start(start2),
        .gmii_txd(g2_txd), .gmii_tx_en(g2_en), .sfd_tx(g2_sfd),
        .busy(g2_busy), .frame_cnt(g2_fcnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    // Frame byte idx (idx 0 = first preamble byte), excluding the FCS.
    function automatic logic [7:0] data_byte(input int plen, input logic [7:0] f0, input int idx);
        logic [47:0] sa;
        sa = 48'h020000000001;
        if (idx < 7)   return 8'h55;
        if (idx == 7)  return 8'hD5;
        if (idx < 14)  return 8'hFF;
        if (idx < 20)  return sa[8*(19-idx) +: 8];
        if (idx == 20) return 8'h88;
        if (idx == 21) return 8'hB5;
        if (idx == 22) return f0;
        return 8'((idx - 23) % 256);
    endfunction

    function automatic logic [31:0] frame_fcs(input int plen, input logic [7:0] f0);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 8; k < 22 + plen; k++) c = crc_byte(c, data_byte(plen, f0, k));
        return ~c;
    endfunction

    function automatic logic [7:0] exp_byte(input int plen, input logic [7:0] f0,
                                            input logic [31:0] fcs, input int idx);
        if (idx < 22 + plen) return data_byte(plen, f0, idx);
        return fcs[8*(idx-22-plen) +: 8];
    endfunction

    localparam int FLEN = 72;   // tx_en cycles per default frame
    localparam int PER  = 84;   // frame plus 12 IPG cycles

    int          m_pos = -1;    // position in frame+IPG, -1 when idle
    logic        m_pend = 1'b0;
    logic [15:0] m_fcnt = '0;
    logic [7:0]  m_f0 = '0;
    logic [31:0] m_fcs = '0;
    logic        preset_req;

    always @(posedge clk or posedge rst0) begin
        if (rst0) begin
            m_pos  <= -1;
            m_pend <= 1'b0;
            m_fcnt <= '0;
            m_f0   <= '0;
            m_fcs  <= '0;
        end else begin
            if (m_pos < 0 || m_pos == PER - 1) begin
                if (start0 || m_pend) begin
                    m_pos <= 0;
                    m_f0  <= m_fcnt[7:0];
                    m_fcs <= frame_fcs(46, m_fcnt[7:0]);
                end else begin
                    m_pos <= -1;
                end
                m_pend <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
                if (start0) m_pend <= 1'b1;
                if (m_pos + 1 == FLEN - 1) m_fcnt <= m_fcnt + 16'd1;
            end
            if (preset_req) m_fcnt <= 16'hFFFF;
        end
    end

    // Per-cycle compare of the default instance plus run/gap statistics.
    logic prev_en = 1'b0;
    int   en_run = 0, last_run = 0, idle_run = 0, last_gap = 0;
    int   sfd_total = 0, s_ctr = 100;
    logic [7:0] pay0_last = 8'h00;

    always @(negedge clk) begin
        chk("tx_en", 32'(g0_en), 32'(m_pos >= 0 && m_pos < FLEN));
        chk("txd", 32'(g0_txd),
            (m_pos >= 0 && m_pos < FLEN) ? 32'(exp_byte(46, m_f0, m_fcs, m_pos)) : 32'h0);
        chk("sfd_tx", 32'(g0_sfd), 32'(m_pos == 7));
        chk("busy", 32'(g0_busy), 32'(m_pos >= 0));
        chk("frame_cnt", 32'(g0_fcnt), 32'(m_fcnt));
        if (g0_en) begin
            en_run   <= prev_en ? en_run + 1 : 1;
            if (!prev_en) last_gap <= idle_run;
            idle_run <= 0;
        end else begin
            if (prev_en) last_run <= en_run;
            idle_run <= idle_run + 1;
            en_run   <= 0;
        end
        prev_en <= g0_en;
        if (g0_sfd) begin
            sfd_total <= sfd_total + 1;
            s_ctr     <= 1;
        end else if (s_ctr < 100) begin
            s_ctr <= s_ctr + 1;
        end
        if (s_ctr == 15) pay0_last <= g0_txd;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic pulse0();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
    endtask

    int         a_t[5];
    logic [7:0] a_p0[5];
    int         a_nf;
    logic [7:0] cap[1600];
    int         j_len, j_rises, j_sfd, j_bad;
    logic       j_prev;

    initial begin
        logic [31:0] c;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start2 = 1'b0;
        zero_start = 1'b0; preset_req = 1'b0;
        tick(2);
        chk("rst_txd", 32'(g0_txd), 32'h0);
        chk("rst_tx_en", 32'(g0_en), 32'h0);
        chk("rst_sfd", 32'(g0_sfd), 32'h0);
        chk("rst_busy", 32'(g0_busy), 32'h0);
        chk("rst_frame_cnt", 32'(g0_fcnt), 32'h0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick(3);

        // Pin the model: CRC check string and a few hand-derived frame bytes.
        c = 32'hFFFFFFFF;
        for (int k = 0; k < 9; k++) c = crc_byte(c, 8'(49 + k));
        chk("model_crc_123456789", ~c, 32'hCBF43926);
        chk("model_sa_byte0", 32'(data_byte(46, 8'h00, 14)), 32'h02);
        chk("model_sa_byte5", 32'(data_byte(46, 8'h00, 19)), 32'h01);
        chk("model_etype_hi", 32'(data_byte(46, 8'h00, 20)), 32'h88);
        chk("model_last_pay", 32'(data_byte(46, 8'h00, 67)), 32'h2C);

        fork
            begin : seq_default
                // single frame
                pulse0();
                tick(90);
                chk("f1_frame_cnt", 32'(g0_fcnt), 32'd1);
                chk("f1_tx_en_len", 32'(last_run), 32'd72);
                chk("f1_sfd_count", 32'(sfd_total), 32'd1);
                chk("f1_pay0", 32'(pay0_last), 32'h00);
                // held start mid-frame queues one frame; a start in IPG is dropped
                pulse0();
                tick(19);
                start0 = 1'b1;
                tick(3);
                start0 = 1'b0;
                tick(55);
                pulse0();
                tick(200);
                chk("b2b_sfd_count", 32'(sfd_total), 32'd3);
                chk("b2b_gap", 32'(last_gap), 32'd12);
                chk("b2b_frame_cnt", 32'(g0_fcnt), 32'd3);
                chk("b2b_tx_en_len", 32'(last_run), 32'd72);
                // asynchronous reset in the payload
                pulse0();
                tick(35);
                rst0 = 1'b1;
                #1;
                chk("arst_tx_en", 32'(g0_en), 32'h0);
                chk("arst_txd", 32'(g0_txd), 32'h0);
                chk("arst_sfd", 32'(g0_sfd), 32'h0);
                chk("arst_busy", 32'(g0_busy), 32'h0);
                chk("arst_frame_cnt", 32'(g0_fcnt), 32'h0);
                tick(2);
                rst0 = 1'b0;
                tick(2);
                pulse0();
                tick(90);
                chk("post_rst_frame_cnt", 32'(g0_fcnt), 32'd1);
                chk("post_rst_tx_en_len", 32'(last_run), 32'd72);
                chk("post_rst_pay0", 32'(pay0_last), 32'h00);
                // frame counter wrap
                #6;
                force u0.frame_cnt_q = 16'hFFFF;
                preset_req = 1'b1;
                tick(1);
                release u0.frame_cnt_q;
                preset_req = 1'b0;
                tick(2);
                pulse0();
                tick(90);
                chk("wrap_frame_cnt", 32'(g0_fcnt), 32'h0);
                chk("wrap_pay0", 32'(pay0_last), 32'hFF);
            end
            begin : seq_auto
                a_nf = 0;
                for (int k = 0; k < 5; k++) begin a_t[k] = 0; a_p0[k] = 8'h00; end
                for (int cy = 0; cy < 1100; cy++) begin
                    @(negedge clk);
                    if (g1_sfd && a_nf < 5) begin
                        a_t[a_nf] = cy;
                        a_nf++;
                    end
                    if (a_nf > 0 && cy == a_t[a_nf-1] + 15) a_p0[a_nf-1] = g1_txd;
                end
                chk("auto_frames", 32'(a_nf), 32'd5);
                for (int k = 1; k < 5; k++) chk("auto_period", 32'(a_t[k] - a_t[k-1]), 32'd200);
                for (int k = 0; k < 5; k++) chk("auto_pay0", 32'(a_p0[k]), 32'(k));
            end
            begin : seq_jumbo
                j_len = 0; j_rises = 0; j_sfd = -1; j_prev = 1'b0; j_bad = 0;
                start2 = 1'b1;
                tick(1);
                start2 = 1'b0;
                for (int cy = 0; cy < 1700; cy++) begin
                    @(negedge clk);
                    if (g2_en) begin
                        if (j_len < 1600) cap[j_len] = g2_txd;
                        if (g2_sfd) j_sfd = j_len;
                        j_len++;
                    end
                    if (g2_en && !j_prev) j_rises++;
                    j_prev = g2_en;
                end
                chk("jumbo_len", 32'(j_len), 32'd1526);
                chk("jumbo_contiguous", 32'(j_rises), 32'd1);
                chk("jumbo_sfd_idx", 32'(j_sfd), 32'd7);
                c = frame_fcs(1500, 8'h00);
                for (int k = 0; k < 1526; k++)
                    if (cap[k] !== exp_byte(1500, 8'h00, c, k)) j_bad++;
                chk("jumbo_bytes_bad", 32'(j_bad), 32'd0);
                c = 32'hFFFFFFFF;
                for (int k = 8; k < 1522; k++) c = crc_byte(c, cap[k]);
                chk("jumbo_rx_crc", {cap[1525], cap[1524], cap[1523], cap[1522]}, ~c);
                chk("jumbo_frame_cnt", 32'(g2_fcnt), 32'd1);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
